// File: rtl/wb_arbiter.sv
// Write-back arbiter: two one-entry result buffers drained oldest-first onto
// a single register file write port, with forwarding and a conflict counter.
module wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] query_addr,
    output logic              query_hit,
    output logic [DATA_W-1:0] query_data,
    output logic [CNT_W-1:0]  conflict_cnt
);
    logic [1:0]        buf_v;
    logic [ADDR_W-1:0] buf_addr [2];
    logic [DATA_W-1:0] buf_data [2];
    logic              old1;
    logic [1:0]        grant;
    logic [1:0]        load;
    logic [1:0]        match;

    always_comb begin
        grant[0] = buf_v[0] && (!buf_v[1] || !old1);
        grant[1] = buf_v[1] && (!buf_v[0] || old1);
    end

    assign req0_ready = !buf_v[0] || grant[0];
    assign req1_ready = !buf_v[1] || grant[1];

    // x0 results are acknowledged but never buffered.
    assign load[0] = req0_valid && req0_ready && (req0_addr != '0);
    assign load[1] = req1_valid && req1_ready && (req1_addr != '0);

    always_comb begin
        write_enable = 1'b0;
        write_addr   = '0;
        write_data   = '0;
        if (grant[0]) begin
            write_enable = 1'b1;
            write_addr   = buf_addr[0];
            write_data   = buf_data[0];
        end else if (grant[1]) begin
            write_enable = 1'b1;
            write_addr   = buf_addr[1];
            write_data   = buf_data[1];
        end
    end

    // On a double match the younger entry holds the newer value.
    always_comb begin
        match[0]   = buf_v[0] && (buf_addr[0] == query_addr) && (query_addr != '0);
        match[1]   = buf_v[1] && (buf_addr[1] == query_addr) && (query_addr != '0);
        query_hit  = |match;
        query_data = '0;
        if (match[0] && match[1])
            query_data = old1 ? buf_data[0] : buf_data[1];
        else if (match[0])
            query_data = buf_data[0];
        else if (match[1])
            query_data = buf_data[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_v        <= '0;
            buf_addr[0]  <= '0;
            buf_addr[1]  <= '0;
            buf_data[0]  <= '0;
            buf_data[1]  <= '0;
            old1         <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            if (load[0]) begin
                buf_v[0]    <= 1'b1;
                buf_addr[0] <= req0_addr;
                buf_data[0] <= req0_data;
            end else if (grant[0]) begin
                buf_v[0] <= 1'b0;
            end
            if (load[1]) begin
                buf_v[1]    <= 1'b1;
                buf_addr[1] <= req1_addr;
                buf_data[1] <= req1_data;
            end else if (grant[1]) begin
                buf_v[1] <= 1'b0;
            end

            if (load[0] && load[1])
                old1 <= 1'b0;
            else if (load[0] && buf_v[1] && !grant[1])
                old1 <= 1'b1;
            else if (load[1] && buf_v[0] && !grant[0])
                old1 <= 1'b0;

            if (buf_v[0] && buf_v[1] && (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter against an acceptance-ordered queue model.
module tb_wb_arbiter;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid;
    logic [ADDR_W-1:0] req0_addr, req1_addr, query_addr;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic              write_enable, query_hit;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data, query_data;
    logic [CNT_W-1:0]  conflict_cnt;

    wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .query_addr(query_addr), .query_hit(query_hit), .query_data(query_data),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                port;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t q[$];
    int   m_cnt;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // A port may send when it has nothing pending or its pending entry is the oldest.
    function automatic bit m_ready(input int p);
        foreach (q[k]) if (q[k].port == p) return (k == 0);
        return 1'b1;
    endfunction

    task automatic check_outputs();
        bit                hit = 1'b0;
        logic [DATA_W-1:0] fd = '0;
        for (int k = 0; k < q.size(); k++)
            if (q[k].addr == query_addr && query_addr != 0) begin
                hit = 1'b1;
                fd  = q[k].data;
            end
        chk("req0_ready", req0_ready, m_ready(0));
        chk("req1_ready", req1_ready, m_ready(1));
        chk("write_enable", write_enable, q.size() > 0);
        chk("write_addr", write_addr, q.size() > 0 ? q[0].addr : 0);
        chk("write_data", write_data, q.size() > 0 ? q[0].data : 0);
        chk("query_hit", query_hit, hit);
        chk("query_data", query_data, fd);
        chk("conflict_cnt", conflict_cnt, m_cnt);
    endtask

    task automatic model_step();
        bit t0 = req0_valid && m_ready(0);
        bit t1 = req1_valid && m_ready(1);
        ent_t e;
        if (q.size() == 2 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (q.size() > 0) void'(q.pop_front());
        if (t0 && req0_addr != 0) begin
            e.port = 0; e.addr = req0_addr; e.data = req0_data; q.push_back(e);
        end
        if (t1 && req1_addr != 0) begin
            e.port = 1; e.addr = req1_addr; e.data = req1_data; q.push_back(e);
        end
    endtask

    task automatic cycle(input bit v0, input int a0, input logic [DATA_W-1:0] d0,
                         input bit v1, input int a1, input logic [DATA_W-1:0] d1, input int qa);
        @(negedge clk);
        req0_valid = v0; req0_addr = a0[ADDR_W-1:0]; req0_data = d0;
        req1_valid = v1; req1_addr = a1[ADDR_W-1:0]; req1_data = d1;
        query_addr = qa[ADDR_W-1:0];
        #1 check_outputs();
        @(posedge clk);
        model_step();
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        query_addr = 0;
        q.delete(); m_cnt = 0;
        #1 check_outputs();
        @(negedge clk); rst = 1'b0;

        // single port, then back-to-back
        cycle(1, 3, 32'h11, 0, 0, 0, 3);
        cycle(0, 0, 0, 0, 0, 0, 3);
        for (int i = 4; i < 8; i++) cycle(1, i, 32'h100 + i, 0, 0, 0, i - 1);
        cycle(0, 0, 0, 0, 0, 0, 7);

        // collision, then same-address age ordering on addr 9
        cycle(1, 5, 32'hA, 1, 6, 32'hB, 6);
        cycle(0, 0, 0, 0, 0, 0, 6);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 8, 32'h80, 1, 9, 32'h91, 9);
        cycle(1, 9, 32'h90, 0, 0, 0, 9);
        cycle(0, 0, 0, 0, 0, 0, 9);
        cycle(0, 0, 0, 0, 0, 0, 9);

        // x0 filter
        cycle(0, 0, 0, 1, 0, 32'hFFFF, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // saturation under permanent contention
        for (int i = 0; i < 24; i++) cycle(1, 10 + (i % 4), i, 1, 20 + (i % 4), ~i, 10);

        // asynchronous reset between edges with both buffers full
        cycle(1, 1, 32'hDEAD, 1, 2, 32'hBEEF, 1);
        #2 rst = 1'b1;
        #1 q.delete(); m_cnt = 0;
        req0_valid = 0; req1_valid = 0;
        check_outputs();
        @(negedge clk); #1 check_outputs();
        @(negedge clk); rst = 1'b0;
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 2);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            int qa = (q.size() > 0 && $urandom_range(0, 1)) ? int'(q[q.size()-1].addr)
                                                             : int'($urandom_range(0, 7));
            cycle($urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom, qa);
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
